// File: rtl/ps2_rx_ctrl.sv
// PS/2 receive controller: synchronises and filters the PS/2 lines, captures one
// 11-bit frame (start, 8 data LSB-first, odd parity, stop) and flags good or bad frames.
module ps2_rx_ctrl #(
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT    = 50000
) (
    input  logic       clk,
    input  logic       i_sclr_n,
    input  logic       i_ps2_clk,
    input  logic       i_ps2_dat,
    output logic [7:0] o_data,
    output logic       o_valid,
    output logic       o_err,
    output logic       o_busy
);

    localparam int FW   = (FILTER_LEN > 2) ? $clog2(FILTER_LEN) : 1;
    localparam int TW   = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
    // The increment that reaches TIMEOUT-1 is the one that aborts the frame.
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT - 2);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        CHECK = 2'd2
    } state_t;

    state_t        r_state, w_state_nxt;
    logic          r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;
    logic          r_filt_clk, r_filt_prev;
    logic [FW-1:0] r_filt_cnt;
    logic [3:0]    r_bit_cnt, w_bit_cnt_nxt;
    logic [TW-1:0] r_to_cnt, w_to_cnt_nxt;
    logic [9:0]    r_shift, w_shift_nxt;
    logic [7:0]    r_data, w_data_nxt;
    logic          r_valid, w_valid_nxt;
    logic          r_err, w_err_nxt;
    logic          w_strobe;
    logic          w_good;

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!i_sclr_n) begin
            r_clk_s1    <= 1'b1;
            r_clk_s2    <= 1'b1;
            r_dat_s1    <= 1'b1;
            r_dat_s2    <= 1'b1;
            r_filt_clk  <= 1'b1;
            r_filt_prev <= 1'b1;
            r_filt_cnt  <= '0;
        end else begin
            r_clk_s1    <= i_ps2_clk;
            r_clk_s2    <= r_clk_s1;
            r_dat_s1    <= i_ps2_dat;
            r_dat_s2    <= r_dat_s1;
            r_filt_prev <= r_filt_clk;
            if (r_clk_s2 == r_filt_clk) begin
                r_filt_cnt <= '0;
            end else if (r_filt_cnt == FILT_LAST) begin
                r_filt_clk <= r_clk_s2;
                r_filt_cnt <= '0;
            end else begin
                r_filt_cnt <= r_filt_cnt + 1'b1;
            end
        end
    end

    assign w_strobe = r_filt_prev & ~r_filt_clk;
    assign w_good   = r_shift[9] & (^r_shift[8:0]);

    always_ff @(posedge clk) begin
        if (!i_sclr_n) begin
            r_state   <= IDLE;
            r_bit_cnt <= '0;
            r_to_cnt  <= '0;
            r_shift   <= '0;
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            r_to_cnt  <= w_to_cnt_nxt;
            r_shift   <= w_shift_nxt;
            r_data    <= w_data_nxt;
            r_valid   <= w_valid_nxt;
            r_err     <= w_err_nxt;
        end
    end

    // NOTE: every output of this block is defaulted first, so no path can infer a latch.
    always_comb begin
        w_state_nxt   = r_state;
        w_bit_cnt_nxt = r_bit_cnt;
        w_to_cnt_nxt  = r_to_cnt;
        w_shift_nxt   = r_shift;
        w_data_nxt    = r_data;
        w_valid_nxt   = 1'b0;
        w_err_nxt     = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_strobe) begin
                    if (r_dat_s2) begin
                        w_err_nxt = 1'b1;
                    end else begin
                        w_state_nxt   = RECV;
                        w_bit_cnt_nxt = '0;
                        w_to_cnt_nxt  = '0;
                    end
                end
            end
            RECV: begin
                if (w_strobe) begin
                    w_shift_nxt   = {r_dat_s2, r_shift[9:1]};
                    w_bit_cnt_nxt = r_bit_cnt + 1'b1;
                    w_to_cnt_nxt  = '0;
                    if (r_bit_cnt == 4'd9) begin
                        w_state_nxt = CHECK;
                    end
                end else if (r_to_cnt == TO_LAST) begin
                    w_err_nxt   = 1'b1;
                    w_shift_nxt = '0;
                    w_state_nxt = IDLE;
                end else begin
                    w_to_cnt_nxt = r_to_cnt + 1'b1;
                end
            end
            CHECK: begin
                w_state_nxt = IDLE;
                if (w_good) begin
                    w_data_nxt  = r_shift[7:0];
                    w_valid_nxt = 1'b1;
                end else begin
                    w_err_nxt = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign o_data  = r_data;
    assign o_valid = r_valid;
    assign o_err   = r_err;
    assign o_busy  = (r_state != IDLE);

endmodule
